// File: rtl/lsu_pkg.sv
// Shared LSU definitions: data/mask widths, responder FSM states and the
// lane-mask expansion helper used on both sides of the data port.
package lsu_pkg;

  localparam int LSU_DW = 64;
  localparam int LSU_MW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Expand an 8-bit byte-lane mask into a 64-bit bit mask.
  function automatic logic [LSU_DW-1:0] mask_expand(input logic [LSU_MW-1:0] mask);
    logic [LSU_DW-1:0] bits;
    bits = '0;
    for (int i = 0; i < LSU_MW; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/lsu_mem_bank.sv
// Single-port DEPTH x 64 RAM with per-byte write enables and a registered
// read port. Contents are not reset.
module lsu_mem_bank
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [LSU_MW-1:0] be,
  input  logic [LSU_DW-1:0] wdata,
  output logic [LSU_DW-1:0] rdata
);

  logic [LSU_DW-1:0] mem [DEPTH];

  // rdata only changes on a read, so it holds steady through a stalled response.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LSU_MW; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the LSU data port: one outstanding load/store,
// fixed response latency, byte-lane masked access to an internal bank.
module lsu_mem_responder
  import lsu_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  input  logic              req_wen,
  input  logic [LSU_DW-1:0] req_wdata,
  input  logic [LSU_MW-1:0] req_mask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LSU_DW-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       cnt_load,
  output logic [31:0]       cnt_store
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a response payload is frozen while stalled.
  lsu_state_e        state;
  logic [3:0]        lat_cnt;
  logic [AW-1:0]     idx_q;
  logic              wen_q;
  logic              err_q;
  logic [LSU_DW-1:0] wdata_q;
  logic [LSU_MW-1:0] mask_q;

  logic              accept;
  logic [63:0]       req_off;
  logic              req_oor;
  logic [AW-1:0]     req_idx;

  logic              bank_en;
  logic              bank_we;
  logic [AW-1:0]     bank_idx;
  logic [LSU_MW-1:0] bank_be;
  logic [LSU_DW-1:0] bank_wdata;
  logic [LSU_DW-1:0] bank_rdata;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid && req_ready;

  assign req_off = req_addr - BASE;
  assign req_oor = (req_addr < BASE) || ((req_off >> 3) >= 64'(DEPTH));
  assign req_idx = req_off[AW+2:3];

  // With LATENCY=1 the access happens on the accepting edge, straight from the
  // request inputs; otherwise it happens on the last BUSY edge from the latches.
  always_comb begin
    bank_en    = 1'b0;
    bank_we    = wen_q;
    bank_idx   = idx_q;
    bank_be    = mask_q;
    bank_wdata = wdata_q;
    if (LATENCY == 1) begin
      bank_en    = accept && !req_oor;
      bank_we    = req_wen;
      bank_idx   = req_idx;
      bank_be    = req_mask;
      bank_wdata = req_wdata;
    end else begin
      bank_en = (state == ST_BUSY) && (lat_cnt == 4'd1) && !err_q;
    end
    bank_en = bank_en && reset;
  end

  lsu_mem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clock (clock),
    .en    (bank_en),
    .we    (bank_we),
    .addr  (bank_idx),
    .be    (bank_be),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      idx_q     <= '0;
      wen_q     <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      mask_q    <= '0;
      cnt_load  <= '0;
      cnt_store <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= req_idx;
            wen_q   <= req_wen;
            err_q   <= req_oor;
            wdata_q <= req_wdata;
            mask_q  <= req_mask;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state   <= ST_BUSY;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
            if (wen_q) begin
              cnt_store <= cnt_store + 32'd1;
            end else begin
              cnt_load <= cnt_load + 32'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !wen_q && !err_q) ? (bank_rdata & mask_expand(mask_q))
                                                       : '0;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: three instances (LATENCY 2, 4, 1) driven with
// directed and random load/store traffic against a word-array reference model.
module tb_lsu_mem_responder;
  import lsu_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          NI    = 3;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic [63:0] req_addr   [NI];
  logic        req_wen    [NI];
  logic [63:0] req_wdata  [NI];
  logic [7:0]  req_mask   [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [63:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic [31:0] cnt_load   [NI];
  logic [31:0] cnt_store  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lsu_mem_responder #(
      .DEPTH   (DEPTH),
      .BASE    (BASE),
      .LATENCY (lat_of(g))
    ) dut (
      .clock      (clock),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .req_wen    (req_wen[g]),
      .req_wdata  (req_wdata[g]),
      .req_mask   (req_mask[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .cnt_load   (cnt_load[g]),
      .cnt_store  (cnt_store[g])
    );
  end

  // ---------------- reference model ----------------
  logic [63:0] mm [NI][DEPTH];
  int          exp_load  [NI];
  int          exp_store [NI];
  logic [63:0] p_addr  [NI];
  logic        p_wen   [NI];
  logic [63:0] p_wdata [NI];
  logic [7:0]  p_mask  [NI];

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } txn_t;
  txn_t exp_q[$];

  int errors = 0;
  int checks = 0;

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  function automatic logic [63:0] model_read(input int k, input logic [63:0] a,
                                             input logic w, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    if (!w && in_range(a)) begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) r[8*i +: 8] = mm[k][widx(a)][8*i +: 8];
      end
    end
    return r;
  endfunction

  task automatic model_write(input int k, input logic [63:0] a,
                             input logic [63:0] d, input logic [7:0] m);
    if (in_range(a)) begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) mm[k][widx(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int k, input logic [63:0] a, input logic w,
                       input logic [63:0] d, input logic [7:0] m);
    @(negedge clock);
    check_val("req_ready_idle", 64'(req_ready[k]), 64'd1);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    req_wen[k]   = w;
    req_wdata[k] = d;
    req_mask[k]  = m;
    p_addr[k]    = a;
    p_wen[k]     = w;
    p_wdata[k]   = d;
    p_mask[k]    = m;
    @(posedge clock);
    #1;
    req_valid[k] = 1'b0;
    req_addr[k]  = {$urandom, $urandom};
    req_wen[k]   = 1'($urandom);
    req_wdata[k] = {$urandom, $urandom};
    req_mask[k]  = 8'($urandom);
  endtask

  task automatic complete(input int k, input int hold, output logic [63:0] got);
    int          n;
    logic [63:0] er;
    logic        ee;
    n = 1;
    while (!resp_valid[k] && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_val("latency", 64'(n), 64'(lat_of(k)));
    er  = model_read(k, p_addr[k], p_wen[k], p_mask[k]);
    ee  = !in_range(p_addr[k]);
    got = resp_rdata[k];
    check_val("rdata", resp_rdata[k], er);
    check_val("err", 64'(resp_err[k]), 64'(ee));
    check_val("req_ready_busy", 64'(req_ready[k]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check_val("stall_valid", 64'(resp_valid[k]), 64'd1);
      check_val("stall_rdata", resp_rdata[k], er);
      check_val("stall_err", 64'(resp_err[k]), 64'(ee));
      check_val("stall_req_ready", 64'(req_ready[k]), 64'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clock);
    #1;
    resp_ready[k] = 1'b0;
    if (p_wen[k]) begin
      model_write(k, p_addr[k], p_wdata[k], p_mask[k]);
      exp_store[k]++;
    end else begin
      exp_load[k]++;
    end
    check_val("cnt_load", 64'(cnt_load[k]), 64'(exp_load[k]));
    check_val("cnt_store", 64'(cnt_store[k]), 64'(exp_store[k]));
    check_val("resp_done", 64'(resp_valid[k]), 64'd0);
  endtask

  task automatic txn(input int k, input logic [63:0] a, input logic w, input logic [63:0] d,
                     input logic [7:0] m, input int hold, output logic [63:0] got);
    issue(k, a, w, d, m);
    complete(k, hold, got);
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE - 64'(8 * $urandom_range(1, 4));
    if (r == 1) return BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 3));
    if (r == 2) return 64'hFFFF_FFFF_FFFF_FFF8;
    return BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
  endfunction

  task automatic check_reset_vals(input int k);
    check_val("rst_req_ready", 64'(req_ready[k]), 64'd1);
    check_val("rst_resp_valid", 64'(resp_valid[k]), 64'd0);
    check_val("rst_rdata", resp_rdata[k], 64'd0);
    check_val("rst_err", 64'(resp_err[k]), 64'd0);
    check_val("rst_cnt_load", 64'(cnt_load[k]), 64'd0);
    check_val("rst_cnt_store", 64'(cnt_store[k]), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] got;
    logic [63:0] last_word;
    int          pushed;
    int          seen;
    int          cyc;
    int          last_cyc;
    txn_t        t;

    for (int k = 0; k < NI; k++) begin
      reset[k]      = 1'b0;
      req_valid[k]  = 1'b0;
      req_addr[k]   = '0;
      req_wen[k]    = 1'b0;
      req_wdata[k]  = '0;
      req_mask[k]   = '0;
      resp_ready[k] = 1'b0;
      exp_load[k]   = 0;
      exp_store[k]  = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < NI; k++) check_reset_vals(k);
    @(negedge clock);
    for (int k = 0; k < NI; k++) reset[k] = 1'b1;

    // Give every word a known value so the model covers the whole array.
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < DEPTH; w++) begin
        txn(k, BASE + 64'(8 * w), 1'b1, {$urandom, $urandom}, 8'hFF, 0, got);
      end
    end

    // Full-word store then load.
    txn(0, 64'h8000_0010, 1'b1, 64'h1122334455667788, 8'hFF, 0, got);
    txn(0, 64'h8000_0010, 1'b0, 64'h0, 8'hFF, 0, got);
    check_val("plan_full_load", got, 64'h1122334455667788);

    // Partial lanes.
    txn(0, 64'h8000_0010, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, got);
    txn(0, 64'h8000_0010, 1'b0, 64'h0, 8'h3C, 0, got);
    check_val("plan_partial_load", got, 64'h0000_3344_AAAA_0000);

    // Out of range on both sides, then the top word is untouched.
    txn(0, BASE + 64'(8 * (DEPTH - 1)), 1'b0, 64'h0, 8'hFF, 0, last_word);
    txn(0, 64'h7FFF_FFF8, 1'b0, 64'h0, 8'hFF, 0, got);
    txn(0, BASE + 64'(8 * DEPTH), 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 0, got);
    txn(0, BASE + 64'(8 * (DEPTH - 1)), 1'b0, 64'h0, 8'hFF, 0, got);
    check_val("plan_oor_unchanged", got, last_word);

    // Mask-zero store is a no-op that still responds.
    txn(0, BASE + 64'd24, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, got);
    txn(0, BASE + 64'd24, 1'b0, 64'h0, 8'hFF, 0, got);

    // Backpressure for 5 cycles on a load.
    txn(0, BASE + 64'd40, 1'b0, 64'h0, 8'hFF, 5, got);

    // Reset one cycle after a store is accepted (LATENCY=4): store never commits.
    issue(1, BASE + 64'd56, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    @(negedge clock);
    reset[1] = 1'b0;
    #1;
    check_reset_vals(1);
    exp_load[1]  = 0;
    exp_store[1] = 0;
    @(negedge clock);
    reset[1] = 1'b1;
    txn(1, BASE + 64'd56, 1'b0, 64'h0, 8'hFF, 0, got);
    check_val("plan_reset_old_data", got, mm[1][7]);

    // Random traffic on all instances.
    for (int i = 0; i < 150; i++) begin
      txn($urandom_range(0, NI - 1), rand_addr(), 1'($urandom_range(0, 1)),
          {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), got);
    end

    // Back-to-back traffic on the LATENCY=1 instance with resp_ready tied high.
    resp_ready[2] = 1'b1;
    pushed   = 0;
    seen     = 0;
    cyc      = 0;
    last_cyc = 0;
    while (seen < 20 && cyc < 200) begin
      @(negedge clock);
      if (req_ready[2] && pushed < 20) begin
        t.addr  = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
        t.wen   = 1'($urandom_range(0, 1));
        t.wdata = {$urandom, $urandom};
        t.mask  = 8'($urandom);
        req_valid[2] = 1'b1;
        req_addr[2]  = t.addr;
        req_wen[2]   = t.wen;
        req_wdata[2] = t.wdata;
        req_mask[2]  = t.mask;
        exp_q.push_back(t);
        pushed++;
      end else if (pushed >= 20) begin
        req_valid[2] = 1'b0;
      end
      @(posedge clock);
      #1;
      cyc++;
      if (resp_valid[2]) begin
        if (exp_q.size() == 0) begin
          check_val("b2b_unexpected_resp", 64'd1, 64'd0);
        end else begin
          t = exp_q.pop_front();
          check_val("b2b_rdata", resp_rdata[2], model_read(2, t.addr, t.wen, t.mask));
          if (t.wen) begin
            model_write(2, t.addr, t.wdata, t.mask);
            exp_store[2]++;
          end else begin
            exp_load[2]++;
          end
        end
        if (seen > 0) check_val("b2b_gap", 64'(cyc - last_cyc), 64'd2);
        last_cyc = cyc;
        seen++;
      end
    end
    check_val("b2b_resp_seen", 64'(seen), 64'd20);
    @(posedge clock);
    #1;
    resp_ready[2] = 1'b0;
    req_valid[2]  = 1'b0;
    check_val("b2b_count", 64'(cnt_load[2] + cnt_store[2]), 64'(exp_load[2] + exp_store[2]));
    check_val("b2b_idle", 64'(resp_valid[2]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
